// File: rtl/register_file_pkg.sv
// Shared types and default sizing for the register file slice.
package register_file_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
  localparam int unsigned DEFAULT_NUM_READ   = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port: zero-register mask, optional write-first bypass, output flop.
module register_file_read_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic                  zero_hit_c;
  logic                  fwd_hit_c;
  logic [DATA_WIDTH-1:0] rd_next_c;

  // Register 0 masking wins over forwarding; forwarding wins over the array.
  always_comb begin
    zero_hit_c = ZERO_REG && (rd_addr == '0);
    fwd_hit_c  = BYPASS && wr_en && (wr_addr == rd_addr);
    rd_next_c  = mem_data;
    if (clear || zero_hit_c) begin
      rd_next_c = '0;
    end else if (fwd_hit_c) begin
      rd_next_c = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next_c;
    end
  end

endmodule

// File: rtl/register_file.sv
// Multi-read, single-write register file that zero-sweeps its array after reset
// before accepting writes.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned NUM_READ   = DEFAULT_NUM_READ,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           regWrite,
  input  logic [ADDR_WIDTH-1:0]          writeAddress,
  input  logic [DATA_WIDTH-1:0]          writeData,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddress,
  output logic [NUM_READ*DATA_WIDTH-1:0] readData,
  output logic                           ready
);

  localparam int unsigned          DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  rf_state_e             state;
  rf_state_e             state_next;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [ADDR_WIDTH-1:0] sweep_cnt_next;
  logic                  ready_next;
  logic                  in_clear;
  logic                  run_we;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      state     <= state_next;
      sweep_cnt <= sweep_cnt_next;
      ready     <= ready_next;
    end
  end

  // Sweep zeroes one entry per cycle; RUN steers the user write onto the array port.
  always_comb begin
    state_next     = state;
    sweep_cnt_next = sweep_cnt;
    in_clear       = 1'b0;
    run_we         = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = writeAddress;
    mem_wdata      = writeData;
    case (state)
      CLEAR: begin
        in_clear       = 1'b1;
        mem_we         = 1'b1;
        mem_waddr      = sweep_cnt;
        mem_wdata      = '0;
        sweep_cnt_next = sweep_cnt + ADDR_WIDTH'(1);
        if (sweep_cnt == LAST_IDX) begin
          state_next = RUN;
        end
      end
      RUN: begin
        run_we = regWrite;
        mem_we = regWrite && !(ZERO_REG && (writeAddress == '0));
      end
      default: state_next = CLEAR;
    endcase
    if (reset) begin
      mem_we = 1'b0;
      run_we = 1'b0;
    end
    ready_next = (state_next == RUN);
  end

  // Array has no reset; contents become defined only through the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_mem;

    assign rd_addr = readAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_mem  = mem[rd_addr];

    register_file_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .clear   (in_clear),
      .wr_en   (run_we),
      .wr_addr (writeAddress),
      .wr_data (writeData),
      .rd_addr (rd_addr),
      .mem_data(rd_mem),
      .rd_data (readData[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: table vectors, reset/sweep sequences,
// and randomized traffic against a behavioural model.
module tb_register_file;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Two default-width instances share stimulus: write-first/zero-reg and read-before-write/no zero-reg.
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [31:0] wd  = '0;
  logic [9:0]  ra  = '0;
  logic [63:0] rd_a, rd_b;
  logic        rdy_a, rdy_b;

  logic        c_rst = 1'b1;
  logic        c_we  = 1'b0;
  logic [2:0]  c_wa  = '0;
  logic [31:0] c_wd  = '0;
  logic [11:0] c_ra  = '0;
  logic [127:0] c_rd;
  logic        c_rdy;

  register_file u_a (
    .clk(clk), .reset(rst), .regWrite(we), .writeAddress(wa), .writeData(wd),
    .readAddress(ra), .readData(rd_a), .ready(rdy_a)
  );

  register_file #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
    .clk(clk), .reset(rst), .regWrite(we), .writeAddress(wa), .writeData(wd),
    .readAddress(ra), .readData(rd_b), .ready(rdy_b)
  );

  register_file #(.ADDR_WIDTH(3), .NUM_READ(4)) u_c (
    .clk(clk), .reset(c_rst), .regWrite(c_we), .writeAddress(c_wa), .writeData(c_wd),
    .readAddress(c_ra), .readData(c_rd), .ready(c_rdy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: cleared-entry count during the sweep, plain arrays once running.
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  int          clr_cnt = 0;
  bit          m_run   = 1'b0;
  logic [31:0] ea0, ea1, eb0, eb1;

  function automatic logic [31:0] ref_a(input logic [4:0] addr, input bit w,
                                        input logic [4:0] wa_i, input logic [31:0] wd_i);
    if (addr == 5'd0) return 32'h0;
    if (w && wa_i == addr) return wd_i;
    return ma[addr];
  endfunction

  task automatic model_step(input bit r, input bit w, input logic [4:0] wa_i,
                            input logic [31:0] wd_i, input logic [4:0] r0, input logic [4:0] r1);
    if (r) begin
      m_run = 1'b0; clr_cnt = 0;
      ea0 = 0; ea1 = 0; eb0 = 0; eb1 = 0;
    end else if (!m_run) begin
      ea0 = 0; ea1 = 0; eb0 = 0; eb1 = 0;
      clr_cnt++;
      if (clr_cnt == 32) begin
        m_run = 1'b1;
        for (int i = 0; i < 32; i++) begin ma[i] = 0; mb[i] = 0; end
      end
    end else begin
      ea0 = ref_a(r0, w, wa_i, wd_i);
      ea1 = ref_a(r1, w, wa_i, wd_i);
      eb0 = mb[r0];
      eb1 = mb[r1];
      if (w && wa_i != 5'd0) ma[wa_i] = wd_i;
      if (w) mb[wa_i] = wd_i;
    end
  endtask

  task automatic tick(input bit r, input bit w, input logic [4:0] wa_i,
                      input logic [31:0] wd_i, input logic [4:0] r0, input logic [4:0] r1);
    rst = r; we = w; wa = wa_i; wd = wd_i; ra = {r1, r0};
    model_step(r, w, wa_i, wd_i, r0, r1);
    @(posedge clk); #1;
    check("a_port0", rd_a[31:0],  ea0);
    check("a_port1", rd_a[63:32], ea1);
    check("b_port0", rd_b[31:0],  eb0);
    check("b_port1", rd_b[63:32], eb1);
    check("a_ready", 32'(rdy_a), 32'(m_run));
    check("b_ready", 32'(rdy_b), 32'(m_run));
  endtask

  task automatic ctick(input bit r, input bit w, input logic [2:0] wa_i,
                       input logic [31:0] wd_i, input logic [11:0] ra_i);
    c_rst = r; c_we = w; c_wa = wa_i; c_wd = wd_i; c_ra = ra_i;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r0, r1;
    logic [31:0] xa0, xa1, xb0, xb1;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int rise;
    int lows;
    logic [11:0] pk;
    logic [31:0] cv [5];

    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd7, 32'h11111111, 5'd1, 5'd2, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[3] = '{1'b1, 5'd7, 32'h22222222, 5'd7, 5'd5, 32'h22222222, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd7, 5'd0, 32'h22222222, 32'h0,        32'h22222222, 32'h0};
    tbl[5] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[6] = '{1'b1, 5'd3, 32'h12345678, 5'd3, 5'd7, 32'h12345678, 32'h22222222, 32'h0,        32'h22222222};
    tbl[7] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};

    // Reset then sweep: writes during the sweep must be ignored, reads zero.
    tick(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    rise = 0;
    if (!rdy_a) begin
      for (int i = 2; i <= 40; i++) begin
        tick(1'b0, (i < 32) ? 1'($urandom_range(0, 1)) : 1'b0, 5'($urandom), $urandom,
             5'($urandom), 5'($urandom));
        if (rdy_a && rise == 0) rise = i;
      end
    end
    check("ready_rise_cycle", 32'(rise), 32'd33);

    for (int i = 0; i < 8; i++) begin
      tick(1'b0, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].r0, tbl[i].r1);
      check($sformatf("tbl%0d_a0", i), rd_a[31:0],  tbl[i].xa0);
      check($sformatf("tbl%0d_a1", i), rd_a[63:32], tbl[i].xa1);
      check($sformatf("tbl%0d_b0", i), rd_b[31:0],  tbl[i].xb0);
      check($sformatf("tbl%0d_b1", i), rd_b[63:32], tbl[i].xb1);
    end

    // Reset during a later sweep at counter 10 restarts the full sweep; reg 3 is lost.
    tick(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    tick(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3);
    lows = 1;
    for (int i = 0; i < 40 && !rdy_a; i++) begin
      tick(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      if (!rdy_a) lows++;
    end
    check("restart_low_cycles", 32'(lows), 32'd32);
    tick(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check("reg3_after_restart_a", rd_a[31:0], 32'h0);
    check("reg3_after_restart_b", rd_b[31:0], 32'h0);

    // Randomized traffic with occasional resets, addresses biased toward collisions.
    for (int i = 0; i < 800; i++) begin
      tick(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom),
           $urandom,
           ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom),
           ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom));
    end
    rst = 1'b0; we = 1'b0;

    // Four-port, 8-entry instance: sweep length and per-port indexing.
    ctick(1'b1, 1'b0, 3'd0, 32'h0, 12'h0);
    lows = 1;
    for (int i = 0; i < 20 && !c_rdy; i++) begin
      ctick(1'b0, 1'b0, 3'd0, 32'h0, 12'h0);
      if (!c_rdy) lows++;
    end
    check("c_sweep_low_cycles", 32'(lows), 32'd8);
    for (int i = 1; i <= 4; i++) begin
      cv[i] = 32'hA5A50000 + 32'(i * 4369);
      ctick(1'b0, 1'b1, 3'(i), cv[i], 12'h0);
    end
    for (int k = 0; k < 4; k++) pk[k*3 +: 3] = 3'(k + 1);
    ctick(1'b0, 1'b0, 3'd0, 32'h0, pk);
    for (int k = 0; k < 4; k++)
      check($sformatf("c_port%0d_fwd", k), c_rd[k*32 +: 32], cv[k + 1]);
    for (int k = 0; k < 4; k++) pk[k*3 +: 3] = 3'(4 - k);
    ctick(1'b0, 1'b0, 3'd0, 32'h0, pk);
    for (int k = 0; k < 4; k++)
      check($sformatf("c_port%0d_rev", k), c_rd[k*32 +: 32], cv[4 - k]);
    ctick(1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 12'h0);
    check("c_zero_write_bypass", c_rd[31:0], 32'h0);
    ctick(1'b0, 1'b0, 3'd0, 32'h0, 12'h0);
    check("c_zero_read_after", c_rd[31:0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of each register and data port in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, sets the address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 Parameter NUM_READ, default 2, sets the number of independent read ports (1..8).
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-005 Parameter BYPASS, default 1; when 1, same-cycle write-to-read forwarding is enabled (write-first); when 0, reads are read-before-write.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 regWrite  input  1  write enable.
REQ-009 writeAddress  input  ADDR_WIDTH  write register index.
REQ-010 writeData  input  DATA_WIDTH  write data.
REQ-011 readAddress  input  NUM_READ*ADDR_WIDTH  packed read indices; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 readData  output  NUM_READ*DATA_WIDTH  packed registered read data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 ready  output  1  high when the clear sweep is complete and writes are accepted.

Function
REQ-014 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-015 In CLEAR, a sweep counter SHALL write zero to register[counter] each cycle, from 0 to DEPTH-1, one register per cycle.
REQ-016 CLEAR SHALL transition to RUN on the cycle after the write to index DEPTH-1; ready SHALL go high on the first RUN cycle.
REQ-017 In CLEAR, regWrite SHALL be ignored and every readData port SHALL load zero.
REQ-018 In RUN, regWrite=1 SHALL store writeData into register[writeAddress] at the clock edge.
REQ-019 With ZERO_REG=1, writes to index 0 SHALL be discarded, and reads of index 0 SHALL return zero regardless of BYPASS.
REQ-020 Read latency SHALL be exactly one cycle: readData port k SHALL reflect readAddress port k as sampled at the preceding edge.
REQ-021 With BYPASS=1, when regWrite=1 in RUN and writeAddress equals readAddress k (and the index is not a zeroed register 0), port k SHALL load writeData.
REQ-022 With BYPASS=0, in the case of REQ-021, port k SHALL load the pre-write register contents.
REQ-023 Multiple read ports addressing the same register SHALL each return the identical value.
REQ-024 readData SHALL hold its value only until the next edge; there is no read enable.

Reset
REQ-025 reset=1 at an edge SHALL force the state to CLEAR, the sweep counter to 0, ready to 0, and all readData to 0.
REQ-026 Assertion of reset mid-sweep or in RUN SHALL restart the sweep from index 0; a write presented in the same cycle as reset SHALL be discarded.
REQ-027 Register contents are guaranteed zero only after ready rises; the array SHALL have no per-entry reset (clearing is performed by the sweep only).

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration (CLEAR, RUN) and the default parameter constants (DATA_WIDTH=32, ADDR_WIDTH=5).
REQ-029 The read port logic SHALL be a generate loop over NUM_READ; one sub-module, regfile_read_port (address compare, bypass mux, zero-register mask, output register), is natural.
REQ-030 The storage array SHALL be a single-write-port memory inferable as distributed RAM or flops.

Verification
REQ-031 Reset 1 cycle, then hold reset low -> ready=0 for exactly 32 cycles and rises on cycle 33; all reads return 0x00000000 throughout.
REQ-032 RUN: write 0xDEADBEEF to reg 5, next cycle read ports 0/1 both at 5 -> both ports return 0xDEADBEEF one cycle later.
REQ-033 BYPASS=1: reg 7 holds 0x11111111; write 0x22222222 to reg 7 while port 0 reads 7 -> port 0 returns 0x22222222; BYPASS=0 -> 0x11111111.
REQ-034 ZERO_REG=1: write 0xFFFFFFFF to reg 0 while port 1 reads 0 -> port 1 returns 0, and a later read of reg 0 returns 0.
REQ-035 Write 0x12345678 to reg 3, assert reset mid-sweep of a later run at counter=10 -> counter restarts at 0, ready stays low for 32 more cycles, and reg 3 reads 0 after ready.
REQ-036 NUM_READ=4, ADDR_WIDTH=3: write distinct values to regs 1..4, read all four ports simultaneously -> each port returns its own register value.
